switch_cell_dispatch_v3: RTL and testbench
==========================================

Name: switch_cell_dispatch_v3

Overview:
Parametrised per-port output cell buffer that sits between the switch core cell output (port-mask write, first/last flags, wide cell data) and the per-port egress logic. It generalises the fixed 4-port, 128-bit output stage to NUM_PORTS ports and CELL_W-bit cells. Each port has frame-atomic store-and-forward behaviour: a frame becomes visible only after its last cell is written, and a frame that overflows is rolled back and dropped. Multicast is supported through the write mask, and per-port backpressure is generated from free space.

Parameters:
NUM_PORTS, 4, number of egress ports
CELL_W, 128, cell data width in bits
DEPTH, 64, cells per port buffer; power of 2, >= 4
MAX_FRAME_CELLS, 32, backpressure threshold; largest legal frame in cells, < DEPTH
PTR_W, $clog2(DEPTH)+1, pointer and count width (derived, not overridden)

Ports:
clk  in  1  system clock; every register is clocked on its rising edge
rstn  in  1  synchronous active-low reset
i_cell_wr  in  NUM_PORTS  per-port write strobe; more than one bit set = multicast
i_cell_din  in  CELL_W  cell data, shared by all ports
i_cell_first  in  1  cell is the first of its frame
i_cell_last  in  1  cell is the last of its frame; first&last = single-cell frame
o_cell_bp  out  NUM_PORTS  per-port backpressure to the core
rd_en  in  NUM_PORTS  per-port pop
rd_valid  out  NUM_PORTS  head cell valid
rd_dout  out  NUM_PORTS*CELL_W  head cell data; port p occupies [p*CELL_W +: CELL_W]
rd_first  out  NUM_PORTS  head cell first flag
rd_last  out  NUM_PORTS  head cell last flag
o_frame_pend  out  NUM_PORTS*PTR_W  per port: frames committed and not yet fully read
o_drop_cnt  out  NUM_PORTS*16  per port: dropped-frame count, saturates at 16'hFFFF

Behaviour:
- Reset (rstn==0 at a clk edge): all pointers, counters and outputs return to 0; every write FSM returns to IDLE. A partially written or partially read frame is discarded. RAM contents are don't-care.
- Per-port state: RAM of DEPTH x (CELL_W+2) holding data, first and last; wr_ptr (committed tail); wr_tmp (speculative tail); rd_ptr. All pointers are PTR_W bits and wrap naturally.
- Free space: free = DEPTH - (wr_tmp - rd_ptr). Use rd_ptr as it stands before any same-cycle pop (conservative).
- Write FSM per port. A port acts only when its i_cell_wr[p] bit is 1; other ports ignore the cell.
  - IDLE:
    - first=1, free>0: write cell at wr_tmp, wr_tmp++.
      - If last=1 also: commit wr_ptr<=wr_tmp+1, stay in IDLE.
      - Otherwise go to RECV.
    - first=0: ignore the cell (stray).
  - RECV:
    - first=1: abandon the open frame (wr_tmp<=wr_ptr, drop_cnt++), then handle the cell as IDLE does.
    - free==0: roll back (wr_tmp<=wr_ptr), drop_cnt++. Go to IDLE if last=1, otherwise go to DISCARD.
    - Otherwise: write the cell, wr_tmp++. If last=1, commit wr_ptr<=wr_tmp+1 and go to IDLE.
  - DISCARD:
    - last=1, first=0: go to IDLE.
    - first=1: handle as IDLE.
    - Otherwise: ignore.
  - In IDLE, first=1 with free==0 is a dropped frame: drop_cnt++. A single-cell frame returns to IDLE; otherwise go to DISCARD.
- Read side: FWFT with a registered output stage.
  - rd_valid[p] is high when the output register holds a committed cell.
  - rd_en while rd_valid pops the head; the next committed cell is presented the following cycle, sustaining 1 cell/cycle.
  - rd_en while !rd_valid is ignored.
- Latency: if the last cell is sampled at edge k, rd_valid rises after edge k+1 when the port was empty.
- o_frame_pend: +1 on commit, -1 when a cell with last=1 is popped; a simultaneous commit and last-pop leaves it unchanged.
- o_cell_bp[p]: registered; 1 when free < MAX_FRAME_CELLS, evaluated every cycle, 1-cycle latency.
- The core is expected to honour bp at frame boundaries. Overflow is handled by the drop path, never by corruption.
- Multicast: each masked port runs its FSM independently, so a frame can be dropped on one port and committed on another.

Test Plan:
- Unicast 3-cell frame, i_cell_wr=4'b0100, no reads -> port 2 only:
  - rd_valid[2]=1 two edges after the last cell; o_frame_pend[2]=1.
  - Three pops return first=1 / -,- / last=1 with data matching.
  - o_frame_pend[2] returns to 0; ports 0, 1 and 3 stay idle.
- Multicast single-cell frame (first=last=1), mask 4'b1011 -> ports 0, 1 and 3 each show frame_pend=1 with identical data; port 2 shows rd_valid=0.
- Overflow, DEPTH=64, no reads:
  - 70-cell frame to port 0 -> o_drop_cnt[0]=1, o_frame_pend[0]=0, rd_valid[0] never asserts.
  - A following 4-cell frame commits with frame_pend=1.
- Backpressure, DEPTH=64, MAX_FRAME_CELLS=32:
  - Commit 33 cells to port 1 -> free=31, o_cell_bp[1]=1 one edge later.
  - Pop one cell -> free=32, bp returns to 0 one edge later.
- Abandon and stray cells:
  - first, mid, then a new first without a last, finished by a last -> drop_cnt=1; only the second frame is readable.
  - A stray cell (first=0) in IDLE is ignored.
- Reset mid-frame: assert rstn=0 for one cycle while cell 2 of 4 is being written -> all outputs 0. A subsequent clean 2-cell frame is read back correctly.

Source files
------------

// File: rtl/switch_cell_dispatch_v3.sv
// switch_cell_dispatch_v3
// Per-port output cell buffer between the switch core and the egress logic.
// Each port stores whole frames before releasing them to the reader, drops
// frames that overflow or are abandoned, and raises backpressure from the
// remaining free space. A multi-bit write mask replicates a cell (multicast).
module switch_cell_dispatch_v3 #(
   parameter  int NUM_PORTS       = 4,
   parameter  int CELL_W          = 128,
   parameter  int DEPTH           = 64,
   parameter  int MAX_FRAME_CELLS = 32,
   localparam int PTR_W           = $clog2(DEPTH) + 1
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_PORTS-1:0]          i_cell_wr,
   input  logic [CELL_W-1:0]             i_cell_din,
   input  logic                          i_cell_first,
   input  logic                          i_cell_last,
   output logic [NUM_PORTS-1:0]          o_cell_bp,
   input  logic [NUM_PORTS-1:0]          rd_en,
   output logic [NUM_PORTS-1:0]          rd_valid,
   output logic [NUM_PORTS*CELL_W-1:0]   rd_dout,
   output logic [NUM_PORTS-1:0]          rd_first,
   output logic [NUM_PORTS-1:0]          rd_last,
   output logic [NUM_PORTS*PTR_W-1:0]    o_frame_pend,
   output logic [NUM_PORTS*16-1:0]       o_drop_cnt
);

   localparam int               AW      = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
   localparam logic [PTR_W-1:0] MAXF_P  = PTR_W'(MAX_FRAME_CELLS);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECV    = 2'd1,
      ST_DISCARD = 2'd2
   } wr_state_t;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [CELL_W+1:0] r_mem [DEPTH];

      wr_state_t         r_state;
      wr_state_t         w_state_nxt;
      logic [PTR_W-1:0]  r_wr_ptr;
      logic [PTR_W-1:0]  r_wr_tmp;
      logic [PTR_W-1:0]  r_rd_ptr;
      logic [PTR_W-1:0]  w_wr_ptr_nxt;
      logic [PTR_W-1:0]  w_wr_tmp_nxt;
      logic [PTR_W-1:0]  w_free;
      logic [PTR_W-1:0]  w_free_base;
      logic [PTR_W-1:0]  w_head;
      logic [AW-1:0]     w_waddr;
      logic              w_we;
      logic              w_start;
      logic              w_commit;
      logic [1:0]        w_drop_inc;
      logic              w_pop;
      logic              w_load;
      logic [16:0]       w_drop_sum;

      logic              r_valid;
      logic              r_first;
      logic              r_last;
      logic [CELL_W-1:0] r_dout;
      logic [PTR_W-1:0]  r_pend;
      logic [15:0]       r_drop;
      logic              r_bp;

      // Free space counts the cell parked in the output register as occupied.
      assign w_free      = DEPTH_P - (r_wr_tmp - r_rd_ptr);
      // Free space once any open frame is rolled back to the committed tail.
      assign w_free_base = DEPTH_P - (r_wr_ptr - r_rd_ptr);

      // Write FSM: next state, RAM write enable/address, pointer updates, drops.
      // Outside an open frame wr_tmp equals wr_ptr, so a new frame always
      // starts from wr_ptr; this also covers the abandon-then-restart case.
      always_comb begin
         w_state_nxt  = r_state;
         w_wr_ptr_nxt = r_wr_ptr;
         w_wr_tmp_nxt = r_wr_tmp;
         w_waddr      = r_wr_tmp[AW-1:0];
         w_we         = 1'b0;
         w_start      = 1'b0;
         w_commit     = 1'b0;
         w_drop_inc   = 2'd0;
         if (i_cell_wr[p]) begin
            case (r_state)
               ST_RECV: begin
                  if (i_cell_first) begin
                     w_drop_inc = 2'd1;
                     w_start    = 1'b1;
                  end else if (w_free == '0) begin
                     w_wr_tmp_nxt = r_wr_ptr;
                     w_drop_inc   = 2'd1;
                     w_state_nxt  = i_cell_last ? ST_IDLE : ST_DISCARD;
                  end else begin
                     w_we         = 1'b1;
                     w_wr_tmp_nxt = r_wr_tmp + 1'b1;
                     if (i_cell_last) begin
                        w_wr_ptr_nxt = r_wr_tmp + 1'b1;
                        w_commit     = 1'b1;
                        w_state_nxt  = ST_IDLE;
                     end
                  end
               end
               ST_DISCARD: begin
                  if (i_cell_first) begin
                     w_start = 1'b1;
                  end else if (i_cell_last) begin
                     w_state_nxt = ST_IDLE;
                  end
               end
               default: begin
                  if (i_cell_first) begin
                     w_start = 1'b1;
                  end
               end
            endcase
            if (w_start) begin
               if (w_free_base != '0) begin
                  w_we         = 1'b1;
                  w_waddr      = r_wr_ptr[AW-1:0];
                  w_wr_tmp_nxt = r_wr_ptr + 1'b1;
                  if (i_cell_last) begin
                     w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                     w_commit     = 1'b1;
                     w_state_nxt  = ST_IDLE;
                  end else begin
                     w_state_nxt  = ST_RECV;
                  end
               end else begin
                  w_wr_tmp_nxt = r_wr_ptr;
                  w_drop_inc   = w_drop_inc + 2'd1;
                  w_state_nxt  = i_cell_last ? ST_IDLE : ST_DISCARD;
               end
            end
         end
      end

      // Read side: pop the head, then prefetch the next committed cell.
      assign w_pop      = rd_en[p] & r_valid;
      assign w_head     = r_rd_ptr + PTR_W'(w_pop);
      assign w_load     = (!r_valid || w_pop) && (r_wr_ptr != w_head);
      assign w_drop_sum = {1'b0, r_drop} + 17'(w_drop_inc);

      // Cell storage; contents need no reset.
      always_ff @(posedge clk) begin
         if (w_we) begin
            r_mem[w_waddr] <= {i_cell_first, i_cell_last, i_cell_din};
         end
      end

      // Pointers, FSM state, output stage, counters and backpressure.
      always_ff @(posedge clk) begin
         if (!rstn) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_wr_tmp <= '0;
            r_rd_ptr <= '0;
            r_valid  <= 1'b0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_dout   <= '0;
            r_pend   <= '0;
            r_drop   <= '0;
            r_bp     <= 1'b0;
         end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_wr_tmp <= w_wr_tmp_nxt;
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            if (w_load) begin
               r_valid                    <= 1'b1;
               {r_first, r_last, r_dout}  <= r_mem[w_head[AW-1:0]];
            end else if (w_pop) begin
               r_valid <= 1'b0;
            end
            case ({w_commit, w_pop & r_last})
               2'b10:   r_pend <= r_pend + 1'b1;
               2'b01:   r_pend <= r_pend - 1'b1;
               default: r_pend <= r_pend;
            endcase
            r_drop <= w_drop_sum[16] ? '1 : w_drop_sum[15:0];
            r_bp   <= (w_free < MAXF_P);
         end
      end

      assign rd_valid[p]                     = r_valid;
      assign rd_first[p]                     = r_first;
      assign rd_last[p]                      = r_last;
      assign rd_dout[p*CELL_W +: CELL_W]     = r_dout;
      assign o_frame_pend[p*PTR_W +: PTR_W]  = r_pend;
      assign o_drop_cnt[p*16 +: 16]          = r_drop;
      assign o_cell_bp[p]                    = r_bp;
   end

endmodule

// File: tb/tb_switch_cell_dispatch_v3.sv
// tb_switch_cell_dispatch_v3
// Directed bench: stimulus pushes expected popped cells into per-port queues,
// a monitor compares every popped head cell against its queue.
module tb_switch_cell_dispatch_v3;

   localparam int NP    = 4;
   localparam int CW    = 128;
   localparam int DEPTH = 64;
   localparam int MAXF  = 32;
   localparam int PW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [CW-1:0] d;
      logic          f;
      logic          l;
   } cell_t;

   logic                 clk;
   logic                 rstn;
   logic [NP-1:0]        i_cell_wr;
   logic [CW-1:0]        i_cell_din;
   logic                 i_cell_first;
   logic                 i_cell_last;
   logic [NP-1:0]        o_cell_bp;
   logic [NP-1:0]        rd_en;
   logic [NP-1:0]        rd_valid;
   logic [NP*CW-1:0]     rd_dout;
   logic [NP-1:0]        rd_first;
   logic [NP-1:0]        rd_last;
   logic [NP*PW-1:0]     o_frame_pend;
   logic [NP*16-1:0]     o_drop_cnt;

   cell_t q [NP][$];
   int    n_checks = 0;
   int    n_fail   = 0;

   switch_cell_dispatch_v3 #(
      .NUM_PORTS(NP),
      .CELL_W(CW),
      .DEPTH(DEPTH),
      .MAX_FRAME_CELLS(MAXF)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .i_cell_wr(i_cell_wr),
      .i_cell_din(i_cell_din),
      .i_cell_first(i_cell_first),
      .i_cell_last(i_cell_last),
      .o_cell_bp(o_cell_bp),
      .rd_en(rd_en),
      .rd_valid(rd_valid),
      .rd_dout(rd_dout),
      .rd_first(rd_first),
      .rd_last(rd_last),
      .o_frame_pend(o_frame_pend),
      .o_drop_cnt(o_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [CW-1:0] mk(input int v);
      logic [31:0] w;
      w = v;
      return {w, w, w, w};
   endfunction

   function automatic logic [63:0] pend(input int p);
      return 64'(o_frame_pend[p*PW +: PW]);
   endfunction

   function automatic logic [63:0] drop(input int p);
      return 64'(o_drop_cnt[p*16 +: 16]);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every pop (valid & rd_en, sampled mid-cycle) is checked.
   always @(negedge clk) begin
      if (rstn) begin
         for (int p = 0; p < NP; p++) begin
            if (rd_valid[p] && rd_en[p]) begin
               cell_t act;
               cell_t exp;
               act = '{rd_dout[p*CW +: CW], rd_first[p], rd_last[p]};
               n_checks++;
               if (q[p].size() == 0) begin
                  n_fail++;
                  $display("FAIL pop_unexpected port %0d: got %0h expected no cell", p, act);
               end else begin
                  exp = q[p].pop_front();
                  if (act !== exp) begin
                     n_fail++;
                     $display("FAIL pop_cell port %0d: got %0h expected %0h", p, act, exp);
                  end
               end
            end
         end
      end
   end

   task automatic send_cell(input logic [NP-1:0] mask, input logic [CW-1:0] d,
                            input logic f, input logic l);
      i_cell_wr    = mask;
      i_cell_din   = d;
      i_cell_first = f;
      i_cell_last  = l;
      @(posedge clk); #1;
      i_cell_wr    = '0;
      i_cell_first = 1'b0;
      i_cell_last  = 1'b0;
   endtask

   task automatic send_frame(input logic [NP-1:0] mask, input int n, input int base,
                             input logic [NP-1:0] exp_mask);
      for (int i = 0; i < n; i++) begin
         logic f;
         logic l;
         f = (i == 0);
         l = (i == n - 1);
         send_cell(mask, mk(base + i), f, l);
         for (int p = 0; p < NP; p++) begin
            if (exp_mask[p]) q[p].push_back('{mk(base + i), f, l});
         end
      end
   endtask

   task automatic pop_n(input int p, input int n);
      int got;
      int guard;
      got   = 0;
      guard = 0;
      rd_en[p] = 1'b1;
      while (got < n && guard < 200) begin
         @(negedge clk);
         if (rd_valid[p]) got++;
         guard++;
         @(posedge clk); #1;
      end
      rd_en[p] = 1'b0;
      if (got < n) begin
         n_checks++;
         n_fail++;
         $display("FAIL pop_timeout port %0d: got %0d pops expected %0d", p, got, n);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rstn         = 1'b0;
      i_cell_wr    = '0;
      i_cell_din   = '0;
      i_cell_first = 1'b0;
      i_cell_last  = 1'b0;
      rd_en        = '0;
      idle(3);
      rstn = 1'b1;
      idle(1);

      // Reset state
      chk("rst_valid", 64'(rd_valid), 64'h0);
      chk("rst_pend", 64'(o_frame_pend), 64'h0);
      chk("rst_drop", o_drop_cnt, 64'h0);
      chk("rst_bp", 64'(o_cell_bp), 64'h0);

      // Unicast 3-cell frame to port 2
      send_frame(4'b0100, 3, 32'h10, 4'b0100);
      chk("uni_valid_k", 64'(rd_valid), 64'h0);
      chk("uni_pend", pend(2), 64'd1);
      idle(1);
      chk("uni_valid_k1", 64'(rd_valid), 64'h4);
      pop_n(2, 3);
      chk("uni_pend_done", pend(2), 64'd0);
      chk("uni_valid_done", 64'(rd_valid), 64'h0);

      // Multicast single-cell frame to ports 0, 1, 3
      send_frame(4'b1011, 1, 32'h20, 4'b1011);
      chk("mc_pend0", pend(0), 64'd1);
      chk("mc_pend1", pend(1), 64'd1);
      chk("mc_pend2", pend(2), 64'd0);
      chk("mc_pend3", pend(3), 64'd1);
      idle(1);
      chk("mc_valid", 64'(rd_valid), 64'hB);
      pop_n(0, 1);
      pop_n(1, 1);
      pop_n(3, 1);

      // Overflow: 70-cell frame into a 64-deep port is dropped
      send_frame(4'b0001, 70, 32'h100, 4'b0000);
      idle(2);
      chk("ovf_drop", drop(0), 64'd1);
      chk("ovf_pend", pend(0), 64'd0);
      chk("ovf_valid", 64'(rd_valid[0]), 64'd0);
      chk("ovf_bp", 64'(o_cell_bp[0]), 64'd0);
      send_frame(4'b0001, 4, 32'h200, 4'b0001);
      chk("ovf_next_pend", pend(0), 64'd1);
      pop_n(0, 4);
      chk("ovf_next_pend_done", pend(0), 64'd0);

      // Backpressure: 33 cells leave 31 free
      send_frame(4'b0010, 33, 32'h300, 4'b0010);
      chk("bp_before", 64'(o_cell_bp[1]), 64'd0);
      idle(1);
      chk("bp_set", 64'(o_cell_bp), 64'h2);
      pop_n(1, 1);
      chk("bp_still", 64'(o_cell_bp[1]), 64'd1);
      idle(1);
      chk("bp_clear", 64'(o_cell_bp[1]), 64'd0);
      pop_n(1, 32);
      chk("bp_pend_done", pend(1), 64'd0);

      // Abandoned frame, then a stray cell in IDLE
      send_cell(4'b1000, mk(32'h400), 1'b1, 1'b0);
      send_cell(4'b1000, mk(32'h401), 1'b0, 1'b0);
      send_cell(4'b1000, mk(32'h500), 1'b1, 1'b0);
      send_cell(4'b1000, mk(32'h501), 1'b0, 1'b1);
      q[3].push_back('{mk(32'h500), 1'b1, 1'b0});
      q[3].push_back('{mk(32'h501), 1'b0, 1'b1});
      chk("abn_drop", drop(3), 64'd1);
      chk("abn_pend", pend(3), 64'd1);
      send_cell(4'b1000, mk(32'h600), 1'b0, 1'b1);
      idle(1);
      chk("stray_pend", pend(3), 64'd1);
      chk("stray_drop", drop(3), 64'd1);
      pop_n(3, 2);
      chk("abn_pend_done", pend(3), 64'd0);

      // Reset in the middle of a 4-cell frame
      send_cell(4'b0001, mk(32'h700), 1'b1, 1'b0);
      i_cell_wr    = 4'b0001;
      i_cell_din   = mk(32'h701);
      i_cell_first = 1'b0;
      i_cell_last  = 1'b0;
      rstn         = 1'b0;
      @(posedge clk); #1;
      rstn      = 1'b1;
      i_cell_wr = '0;
      for (int p = 0; p < NP; p++) q[p].delete();
      chk("mrst_valid", 64'(rd_valid), 64'h0);
      chk("mrst_pend", 64'(o_frame_pend), 64'h0);
      chk("mrst_drop", o_drop_cnt, 64'h0);
      chk("mrst_bp", 64'(o_cell_bp), 64'h0);
      chk("mrst_dout_zero", 64'(rd_dout == '0), 64'd1);
      send_cell(4'b0001, mk(32'h702), 1'b0, 1'b0);
      send_cell(4'b0001, mk(32'h703), 1'b0, 1'b1);
      idle(1);
      chk("mrst_tail_pend", pend(0), 64'd0);
      chk("mrst_tail_valid", 64'(rd_valid[0]), 64'd0);
      send_frame(4'b0001, 2, 32'h800, 4'b0001);
      chk("mrst_clean_pend", pend(0), 64'd1);
      pop_n(0, 2);
      chk("mrst_clean_done", pend(0), 64'd0);

      idle(2);
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("queue_empty_p%0d", p), 64'(q[p].size()), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
